// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and constants for the datapath control unit
// Contents: state_t (FSM states, encodings double as the upc debug value),
//           OP_* instruction opcodes, ALU_* datapath op codes, pc_index().
package datapath_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_PCINC  = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_NOP  = 4'd7;
  localparam logic [3:0] OP_LDI  = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_BRZ  = 4'd11;
  localparam logic [3:0] OP_BRN  = 4'd12;
  localparam logic [3:0] OP_BRO  = 4'd13;
  localparam logic [3:0] OP_BRA  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_MOV = 3'b110;
  localparam logic [2:0] ALU_INC = 3'b111;

  // The PC lives in the highest-numbered register.
  function automatic int unsigned pc_index(input int unsigned m);
    return (32'd1 << m) - 32'd1;
  endfunction

endpackage

// File: rtl/datapath_ctrl_if.sv
// rtl/datapath_ctrl_if.sv - instruction fetch and data-memory handshake bundle
// Signals: instr/instr_valid/instr_req (instruction fetch),
//          mem_ready/dmem_addr_ld/dmem_we (data-memory access).
// Modports: master = memory side, slave = controller side.
interface datapath_ctrl_if #(
  parameter int IW = 16
) ();

  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_req;
  logic          mem_ready;
  logic          dmem_addr_ld;
  logic          dmem_we;

  modport master (
    output instr, instr_valid, mem_ready,
    input  instr_req, dmem_addr_ld, dmem_we
  );

  modport slave (
    input  instr, instr_valid, mem_ready,
    output instr_req, dmem_addr_ld, dmem_we
  );

endinterface

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational map from (state, IR, latched flags) to controls
// Inputs:  i_state, i_ir, latched flags i_z/i_n/i_o, i_mem_ready.
// Outputs: fetch/memory strobes, datapath controls, register addresses,
//          offset, upc, halted, and o_branch_taken for the sequencer.
module ctrl_decode
  import datapath_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 8,
  parameter int IW = 16
) (
  input  state_t          i_state,
  input  logic [IW-1:0]   i_ir,
  input  logic            i_z,
  input  logic            i_n,
  input  logic            i_o,
  input  logic            i_mem_ready,
  output logic            o_instr_req,
  output logic            o_halted,
  output logic            o_dmem_addr_ld,
  output logic            o_dmem_we,
  output logic            o_ie,
  output logic            o_write,
  output logic            o_reada,
  output logic            o_readb,
  output logic            o_en,
  output logic            o_oe,
  output logic            o_bypassa,
  output logic            o_bypassb,
  output logic            o_mov_sel,
  output logic [2:0]      o_op,
  output logic [2:0]      o_upc,
  output logic [M-1:0]    o_waddr,
  output logic [M-1:0]    o_ra,
  output logic [M-1:0]    o_rb,
  output logic [N-1:0]    o_offset,
  output logic            o_branch_taken
);

  localparam int          W  = IW - 4 - M;
  localparam logic [M-1:0] PC = M'(pc_index(M));

  logic [3:0]   w_opcode;
  logic [M-1:0] w_rd;
  logic [M-1:0] w_ra;
  logic [M-1:0] w_rb;
  logic [W-1:0] w_imm;
  logic [N-1:0] w_sext;
  logic         w_cond;

  assign w_opcode = i_ir[IW-1:IW-4];
  assign w_rd     = i_ir[IW-5 -: M];
  assign w_ra     = i_ir[IW-5-M -: M];
  assign w_rb     = i_ir[IW-5-2*M -: M];
  assign w_imm    = i_ir[W-1:0];

  // imm overlaps the ra/rb fields; it is narrower or wider than a word
  // depending on the parameters, so extend or truncate accordingly.
  generate
    if (W < N) begin : g_sext
      assign w_sext = {{(N-W){w_imm[W-1]}}, w_imm};
    end else begin : g_trunc
      logic w_unused_imm;
      assign w_sext       = w_imm[N-1:0];
      assign w_unused_imm = ^w_imm;
    end
  endgenerate

  always_comb begin
    w_cond = 1'b0;
    case (w_opcode)
      OP_BRZ:  w_cond = i_z;
      OP_BRN:  w_cond = i_n;
      OP_BRO:  w_cond = i_o;
      OP_BRA:  w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  assign o_branch_taken = w_cond;

  always_comb begin
    o_instr_req    = 1'b0;
    o_halted       = 1'b0;
    o_dmem_addr_ld = 1'b0;
    o_dmem_we      = 1'b0;
    o_ie           = 1'b0;
    o_write        = 1'b0;
    o_reada        = 1'b0;
    o_readb        = 1'b0;
    o_en           = 1'b0;
    o_oe           = 1'b0;
    o_bypassa      = 1'b0;
    o_bypassb      = 1'b0;
    o_mov_sel      = 1'b0;
    o_op           = 3'b000;
    o_upc          = i_state;
    o_waddr        = '0;
    o_ra           = '0;
    o_rb           = '0;
    o_offset       = '0;
    case (i_state)
      S_FETCH: o_instr_req = 1'b1;
      S_DECODE: begin
        o_reada = 1'b1;
        o_readb = 1'b1;
        o_ra    = w_ra;
        o_rb    = w_rb;
      end
      S_EXEC: begin
        case (w_opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
            o_reada = 1'b1;
            o_readb = 1'b1;
            o_ra    = w_ra;
            o_rb    = w_rb;
            o_en    = 1'b1;
            o_write = 1'b1;
            o_waddr = w_rd;
            o_op    = w_opcode[2:0];
          end
          OP_LDI: begin
            o_bypassa = 1'b1;
            o_bypassb = 1'b1;
            o_op      = ALU_MOV;
            o_offset  = w_sext;
            o_en      = 1'b1;
            o_write   = 1'b1;
            o_waddr   = w_rd;
          end
          // Address phase shared by load and store: ra passes through to dout.
          OP_LD, OP_ST: begin
            o_ra           = w_ra;
            o_reada        = 1'b1;
            o_op           = ALU_MOV;
            o_en           = 1'b1;
            o_oe           = 1'b1;
            o_dmem_addr_ld = 1'b1;
          end
          OP_BRZ, OP_BRN, OP_BRO, OP_BRA: begin
            if (w_cond) begin
              o_ra      = PC;
              o_reada   = 1'b1;
              o_bypassb = 1'b1;
              o_offset  = w_sext;
              o_op      = ALU_ADD;
              o_en      = 1'b1;
              o_write   = 1'b1;
              o_oe      = 1'b1;
              o_waddr   = PC;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (w_opcode == OP_LD) begin
          // Write-back only in the cycle memory returns data.
          if (i_mem_ready) begin
            o_ie    = 1'b1;
            o_write = 1'b1;
            o_waddr = w_rd;
          end
        end else begin
          o_reada   = 1'b1;
          o_readb   = 1'b1;
          o_ra      = w_ra;
          o_rb      = w_rb;
          o_mov_sel = 1'b1;
          o_en      = 1'b1;
          o_oe      = 1'b1;
          o_dmem_we = 1'b1;
        end
      end
      S_PCINC: begin
        o_ra    = PC;
        o_reada = 1'b1;
        o_op    = ALU_INC;
        o_en    = 1'b1;
        o_write = 1'b1;
        o_oe    = 1'b1;
        o_waddr = PC;
      end
      S_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - microcoded sequencer driving the register-file datapath
// Ports: clk, rst (async, active-high); bus (fetch + data-memory handshake);
//        z_flag/n_flag/o_flag from the datapath; datapath controls ie, write,
//        reada, readb, en, oe, bypassa, bypassb, mov_sel, op, waddr, ra, rb,
//        offset; debug upc; halted.
module datapath_ctrl
  import datapath_pkg::*;
#(
  parameter int M  = 3,
  parameter int N  = 8,
  parameter int IW = 16
) (
  input  logic           clk,
  input  logic           rst,
  datapath_ctrl_if.slave bus,
  input  logic           z_flag,
  input  logic           n_flag,
  input  logic           o_flag,
  output logic           ie,
  output logic           write,
  output logic           reada,
  output logic           readb,
  output logic           en,
  output logic           oe,
  output logic           bypassa,
  output logic           bypassb,
  output logic           mov_sel,
  output logic [2:0]     op,
  output logic [M-1:0]   waddr,
  output logic [M-1:0]   ra,
  output logic [M-1:0]   rb,
  output logic [N-1:0]   offset,
  output logic [2:0]     upc,
  output logic           halted
);

  state_t        r_state;
  logic [IW-1:0] r_ir;
  logic          r_z;
  logic          r_n;
  logic          r_o;
  logic [3:0]    w_opcode;
  logic          w_branch_taken;

  assign w_opcode = r_ir[IW-1:IW-4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_o     <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.instr_valid) begin
            r_ir    <= bus.instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_opcode == OP_NOP)       r_state <= S_PCINC;
          else if (w_opcode == OP_HALT) r_state <= S_HALT;
          else                          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_opcode <= OP_MOV) begin
            // Only ALU ops update the branch flags.
            r_z     <= z_flag;
            r_n     <= n_flag;
            r_o     <= o_flag;
            r_state <= S_PCINC;
          end else if (w_opcode == OP_LD || w_opcode == OP_ST) begin
            r_state <= S_MEM;
          end else if (w_branch_taken) begin
            // Taken branch already wrote PC+offset, so skip the increment.
            r_state <= S_FETCH;
          end else begin
            r_state <= S_PCINC;
          end
        end
        S_MEM:   if (bus.mem_ready) r_state <= S_PCINC;
        S_PCINC: r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_decode #(
    .M  (M),
    .N  (N),
    .IW (IW)
  ) u_decode (
    .i_state        (r_state),
    .i_ir           (r_ir),
    .i_z            (r_z),
    .i_n            (r_n),
    .i_o            (r_o),
    .i_mem_ready    (bus.mem_ready),
    .o_instr_req    (bus.instr_req),
    .o_halted       (halted),
    .o_dmem_addr_ld (bus.dmem_addr_ld),
    .o_dmem_we      (bus.dmem_we),
    .o_ie           (ie),
    .o_write        (write),
    .o_reada        (reada),
    .o_readb        (readb),
    .o_en           (en),
    .o_oe           (oe),
    .o_bypassa      (bypassa),
    .o_bypassb      (bypassb),
    .o_mov_sel      (mov_sel),
    .o_op           (op),
    .o_upc          (upc),
    .o_waddr        (waddr),
    .o_ra           (ra),
    .o_rb           (rb),
    .o_offset       (offset),
    .o_branch_taken (w_branch_taken)
  );

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - scoreboard bench for datapath_ctrl
module tb_datapath_ctrl;

  localparam int M  = 3;
  localparam int N  = 8;
  localparam int IW = 16;

  // Control bit positions in the expected-vector control field.
  localparam logic [12:0] REQ  = 13'h1000;
  localparam logic [12:0] HLT  = 13'h0800;
  localparam logic [12:0] IE   = 13'h0400;
  localparam logic [12:0] WR   = 13'h0200;
  localparam logic [12:0] RDA  = 13'h0100;
  localparam logic [12:0] RDB  = 13'h0080;
  localparam logic [12:0] EN   = 13'h0040;
  localparam logic [12:0] OE   = 13'h0020;
  localparam logic [12:0] BPA  = 13'h0010;
  localparam logic [12:0] BPB  = 13'h0008;
  localparam logic [12:0] MSEL = 13'h0004;
  localparam logic [12:0] ADL  = 13'h0002;
  localparam logic [12:0] WE   = 13'h0001;

  typedef logic [35:0] vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           z_flag, n_flag, o_flag;
  logic           ie, write, reada, readb, en, oe, bypassa, bypassb, mov_sel;
  logic [2:0]     op, upc;
  logic [M-1:0]   waddr, ra, rb;
  logic [N-1:0]   offset;
  logic           halted;

  datapath_ctrl_if #(.IW(IW)) bus_if ();

  datapath_ctrl #(.M(M), .N(N), .IW(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .z_flag  (z_flag),
    .n_flag  (n_flag),
    .o_flag  (o_flag),
    .ie      (ie),
    .write   (write),
    .reada   (reada),
    .readb   (readb),
    .en      (en),
    .oe      (oe),
    .bypassa (bypassa),
    .bypassb (bypassb),
    .mov_sel (mov_sel),
    .op      (op),
    .waddr   (waddr),
    .ra      (ra),
    .rb      (rb),
    .offset  (offset),
    .upc     (upc),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  vec_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  vec_t  w_act;
  vec_t  m_exp;
  string m_name;

  assign w_act = {upc, bus_if.instr_req, halted, ie, write, reada, readb, en, oe,
                  bypassa, bypassb, mov_sel, bus_if.dmem_addr_ld, bus_if.dmem_we,
                  op, waddr, ra, rb, offset};

  // Monitor: one expected vector per cycle while the scoreboard holds any.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      n_checks++;
      if (w_act === m_exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", m_name, w_act, m_exp);
    end
  end

  task automatic ex(input string nm, input logic [2:0] u, input logic [12:0] c,
                    input logic [2:0] o, input logic [2:0] wa, input logic [2:0] a,
                    input logic [2:0] b, input logic [7:0] off);
    exp_q.push_back({u, c, o, wa, a, b, off});
    name_q.push_back(nm);
  endtask

  task automatic ex_fetch(input string nm);
    ex(nm, 3'd0, REQ, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
  endtask

  task automatic ex_pcinc(input string nm);
    ex(nm, 3'd4, RDA | EN | WR | OE, 3'd7, 3'd7, 3'd7, 3'd0, 8'h00);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] enc(input logic [3:0] o, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return {o, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] enci(input logic [3:0] o, input logic [2:0] d,
                                       input logic [8:0] imm);
    return {o, d, imm};
  endfunction

  task automatic drive(input logic [15:0] ins, input int n, input logic [15:0] mr,
                       input logic z, input logic nf, input logic of, input int vcyc);
    bus_if.instr = ins;
    z_flag = z;
    n_flag = nf;
    o_flag = of;
    for (int k = 0; k < n; k++) begin
      bus_if.instr_valid = (k < vcyc);
      bus_if.mem_ready   = mr[k];
      cyc();
    end
    bus_if.instr_valid = 1'b0;
    bus_if.mem_ready   = 1'b0;
  endtask

  // Assert reset part-way through a cycle so the sampled vector shows the
  // asynchronous drop before any clock edge.
  task automatic mid_reset(input string nm);
    ex_fetch(nm);
    #1 rst = 1'b1;
    cyc();
    ex_fetch({nm, "_hold"});
    rst = 1'b0;
    bus_if.mem_ready = 1'b0;
    cyc();
  endtask

  task automatic alu_dec(input string nm, input logic [2:0] a, input logic [2:0] b);
    ex(nm, 3'd1, RDA | RDB, 3'd0, 3'd0, a, b, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    z_flag = 1'b0; n_flag = 1'b0; o_flag = 1'b0;
    bus_if.instr = '0;
    bus_if.instr_valid = 1'b0;
    bus_if.mem_ready = 1'b0;
    ex_fetch("reset");
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) ex_fetch("idle");
    repeat (5) cyc();

    // LDI r2, 20
    ex_fetch("ldi_f"); alu_dec("ldi_dec", 3'd0, 3'd2);
    ex("ldi_exec", 3'd2, BPA | BPB | EN | WR, 3'd6, 3'd2, 3'd0, 3'd0, 8'h14);
    ex_pcinc("ldi_pcinc");
    drive(enci(4'd8, 3'd2, 9'd20), 4, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // ADD r3 = r0 + r1, result nonzero
    ex_fetch("add_f"); alu_dec("add_dec", 3'd0, 3'd1);
    ex("add_exec", 3'd2, RDA | RDB | EN | WR, 3'd0, 3'd3, 3'd0, 3'd1, 8'h00);
    ex_pcinc("add_pcinc");
    drive(enc(4'd0, 3'd3, 3'd0, 3'd1), 4, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // BRZ -2, not taken
    ex_fetch("brz_nt_f"); alu_dec("brz_nt_dec", 3'd7, 3'd7);
    ex("brz_nt_exec", 3'd2, 13'h0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    ex_pcinc("brz_nt_pcinc");
    drive(enci(4'd11, 3'd0, 9'h1FE), 4, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // SUB r3 = r1 - r1, Z=1
    ex_fetch("sub_f"); alu_dec("sub_dec", 3'd1, 3'd1);
    ex("sub_exec", 3'd2, RDA | RDB | EN | WR, 3'd1, 3'd3, 3'd1, 3'd1, 8'h00);
    ex_pcinc("sub_pcinc");
    drive(enc(4'd1, 3'd3, 3'd1, 3'd1), 4, 16'h0, 1'b1, 1'b0, 1'b0, 1);

    // BRZ -2, taken (raw z input low: only the latched flag matters)
    ex_fetch("brz_tk_f"); alu_dec("brz_tk_dec", 3'd7, 3'd7);
    ex("brz_tk_exec", 3'd2, RDA | BPB | EN | WR | OE, 3'd0, 3'd7, 3'd7, 3'd0, 8'hFE);
    drive(enci(4'd11, 3'd0, 9'h1FE), 3, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // ST [r2] <- r3, mem_ready high in F/D/E (ignored), low 3 MEM cycles
    ex_fetch("st_f"); alu_dec("st_dec", 3'd2, 3'd3);
    ex("st_addr", 3'd2, RDA | EN | OE | ADL, 3'd6, 3'd0, 3'd2, 3'd0, 8'h00);
    for (int i = 0; i < 4; i++)
      ex("st_mem", 3'd3, RDA | RDB | MSEL | EN | OE | WE, 3'd0, 3'd0, 3'd2, 3'd3, 8'h00);
    ex_pcinc("st_pcinc");
    drive(enc(4'd10, 3'd0, 3'd2, 3'd3), 8, 16'b0100_0111, 1'b0, 1'b0, 1'b0, 1);

    // LD r5 <- [r4], memory ready at once
    ex_fetch("ld_f"); alu_dec("ld_dec", 3'd4, 3'd0);
    ex("ld_addr", 3'd2, RDA | EN | OE | ADL, 3'd6, 3'd0, 3'd4, 3'd0, 8'h00);
    ex("ld_mem", 3'd3, IE | WR, 3'd0, 3'd5, 3'd0, 3'd0, 8'h00);
    ex_pcinc("ld_pcinc");
    drive(enc(4'd9, 3'd5, 3'd4, 3'd0), 5, 16'b0_1000, 1'b0, 1'b0, 1'b0, 1);

    // NOP
    ex_fetch("nop_f"); alu_dec("nop_dec", 3'd0, 3'd0);
    ex_pcinc("nop_pcinc");
    drive(enc(4'd7, 3'd0, 3'd0, 3'd0), 3, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // BRA +5
    ex_fetch("bra_f"); alu_dec("bra_dec", 3'd0, 3'd0);
    ex("bra_exec", 3'd2, RDA | BPB | EN | WR | OE, 3'd0, 3'd7, 3'd7, 3'd0, 8'h05);
    drive(enci(4'd14, 3'd0, 9'd5), 3, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    // XOR r1 = r2 ^ r3 with N=1, then BRN taken, BRO not taken
    ex_fetch("xor_f"); alu_dec("xor_dec", 3'd2, 3'd3);
    ex("xor_exec", 3'd2, RDA | RDB | EN | WR, 3'd4, 3'd1, 3'd2, 3'd3, 8'h00);
    ex_pcinc("xor_pcinc");
    drive(enc(4'd4, 3'd1, 3'd2, 3'd3), 4, 16'h0, 1'b0, 1'b1, 1'b0, 1);

    ex_fetch("brn_f"); alu_dec("brn_dec", 3'd0, 3'd0);
    ex("brn_exec", 3'd2, RDA | BPB | EN | WR | OE, 3'd0, 3'd7, 3'd7, 3'd0, 8'h03);
    drive(enci(4'd12, 3'd0, 9'd3), 3, 16'h0, 1'b0, 1'b0, 1'b0, 1);

    ex_fetch("bro_f"); alu_dec("bro_dec", 3'd0, 3'd0);
    ex("bro_exec", 3'd2, 13'h0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    ex_pcinc("bro_pcinc");
    drive(enci(4'd13, 3'd0, 9'd3), 4, 16'h0, 1'b0, 1'b0, 1'b1, 1);

    // Latch Z=1 again, then reset during a stalled store
    ex_fetch("sub2_f"); alu_dec("sub2_dec", 3'd1, 3'd1);
    ex("sub2_exec", 3'd2, RDA | RDB | EN | WR, 3'd1, 3'd3, 3'd1, 3'd1, 8'h00);
    ex_pcinc("sub2_pcinc");
    drive(enc(4'd1, 3'd3, 3'd1, 3'd1), 4, 16'h0, 1'b1, 1'b0, 1'b0, 1);

    ex_fetch("st2_f"); alu_dec("st2_dec", 3'd2, 3'd3);
    ex("st2_addr", 3'd2, RDA | EN | OE | ADL, 3'd6, 3'd0, 3'd2, 3'd0, 8'h00);
    ex("st2_mem", 3'd3, RDA | RDB | MSEL | EN | OE | WE, 3'd0, 3'd0, 3'd2, 3'd3, 8'h00);
    drive(enc(4'd10, 3'd0, 3'd2, 3'd3), 4, 16'h0, 1'b0, 1'b0, 1'b0, 1);
    mid_reset("st_rst");

    // Flags were cleared by reset: BRZ falls through even with raw z high
    ex_fetch("brz_rst_f"); alu_dec("brz_rst_dec", 3'd7, 3'd7);
    ex("brz_rst_exec", 3'd2, 13'h0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    ex_pcinc("brz_rst_pcinc");
    drive(enci(4'd11, 3'd0, 9'h1FE), 4, 16'h0, 1'b1, 1'b0, 1'b0, 1);

    // Reset while a load is writing back
    ex_fetch("ld2_f"); alu_dec("ld2_dec", 3'd4, 3'd0);
    ex("ld2_addr", 3'd2, RDA | EN | OE | ADL, 3'd6, 3'd0, 3'd4, 3'd0, 8'h00);
    drive(enc(4'd9, 3'd5, 3'd4, 3'd0), 3, 16'h0, 1'b0, 1'b0, 1'b0, 1);
    bus_if.mem_ready = 1'b1;
    mid_reset("ld_rst");

    // HALT absorbs instr_valid for 10 cycles
    ex_fetch("halt_f"); alu_dec("halt_dec", 3'd0, 3'd0);
    for (int i = 0; i < 10; i++) ex("halt", 3'd7, HLT, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    drive(enc(4'd15, 3'd0, 3'd0, 3'd0), 12, 16'h0, 1'b0, 1'b0, 1'b0, 12);
    mid_reset("halt_rst");
    ex_fetch("final");
    cyc();
    cyc();

    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
